// File: rtl/mod_sample_sched_pkg.sv
// rtl/mod_sample_sched_pkg.sv - shared mode/state encodings for the sample scheduler
package mod_sample_sched_pkg;

  typedef enum logic [1:0] {
    MODE_ASK  = 2'd0,
    MODE_FSK  = 2'd1,
    MODE_PSK  = 2'd2,
    MODE_DPSK = 2'd3
  } mode_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BLANK = 2'd1,
    ST_RUN   = 2'd2
  } state_t;

  localparam logic [9:0] MIDSCALE_CODE = 10'd512;

  // Only called when some key is down, so DPSK is implied when the others are low.
  function automatic mode_t key_priority(input logic ask, input logic fsk, input logic psk);
    if (ask) return MODE_ASK;
    if (fsk) return MODE_FSK;
    if (psk) return MODE_PSK;
    return MODE_DPSK;
  endfunction

endpackage

// File: rtl/mss_tick_div.sv
// rtl/mss_tick_div.sv - free-running divider producing a one-cycle sample tick
module mss_tick_div #(
  parameter int DIV = 1000
) (
  input  logic clk,
  input  logic reset_n,
  output logic tick
);

  localparam int W = $clog2(DIV);

  logic [W-1:0] count;

  assign tick = (count == W'(DIV - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (tick) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/mod_sample_sched.sv
// rtl/mod_sample_sched.sv - mode selection, midscale blanking and paced DAC hand-off
module mod_sample_sched
  import mod_sample_sched_pkg::*;
#(
  parameter int         SAMPLE_DIV    = 1000,
  parameter int         DWELL_TICKS   = 5000,
  parameter int         BLANK_SAMPLES = 4,
  parameter logic [9:0] MIDSCALE      = MIDSCALE_CODE
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       set_ask,
  input  logic       set_fsk,
  input  logic       set_psk,
  input  logic       set_dpsk,
  input  logic       auto_en,
  input  logic [9:0] ask_in,
  input  logic [9:0] fsk_in,
  input  logic [9:0] psk_in,
  input  logic [9:0] dpsk_in,
  input  logic       dac_ready,
  output logic       dac_load,
  output logic [9:0] dac_data,
  output logic [1:0] mode,
  output logic       mode_active,
  output logic [7:0] overrun_cnt
);

  localparam int DW = $clog2(DWELL_TICKS + 1);
  localparam int BW = $clog2(BLANK_SAMPLES + 1);

  logic          tick;
  state_t        state;
  mode_t         cur_mode, req_mode, key_sel, eff_req;
  logic          req_valid, key_hit, have_req, run_next, dwell_done;
  logic [DW-1:0] dwell;
  logic [BW-1:0] blank_cnt;
  logic [9:0]    sample_word, tick_word, pend_word, held_word;
  logic          pending;

  mss_tick_div #(.DIV(SAMPLE_DIV)) u_tick_div (
    .clk     (clk),
    .reset_n (reset_n),
    .tick    (tick)
  );

  assign key_hit    = set_ask | set_fsk | set_psk | set_dpsk;
  assign key_sel    = key_priority(set_ask, set_fsk, set_psk);
  assign have_req   = key_hit | req_valid;
  assign eff_req    = key_hit ? key_sel : req_mode;
  assign dwell_done = auto_en && (dwell == DW'(DWELL_TICKS));

  // The word emitted at a tick follows the state being entered: samples only in RUN.
  assign run_next = have_req ? (state == ST_RUN && eff_req == cur_mode)
                             : ((state == ST_BLANK && blank_cnt == '0) ||
                                (state == ST_RUN && !dwell_done));

  always_comb begin
    sample_word = ask_in;
    case (cur_mode)
      MODE_ASK:  sample_word = ask_in;
      MODE_FSK:  sample_word = fsk_in;
      MODE_PSK:  sample_word = psk_in;
      MODE_DPSK: sample_word = dpsk_in;
      default:   sample_word = ask_in;
    endcase
  end

  assign tick_word = run_next ? sample_word : MIDSCALE;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      cur_mode    <= MODE_ASK;
      mode_active <= 1'b0;
      blank_cnt   <= '0;
      dwell       <= '0;
      req_valid   <= 1'b0;
      req_mode    <= MODE_ASK;
    end else begin
      if (!auto_en) dwell <= '0;
      if (tick) begin
        req_valid <= 1'b0;
        if (have_req && !(state == ST_RUN && eff_req == cur_mode)) begin
          cur_mode    <= eff_req;
          mode_active <= 1'b1;
          state       <= ST_BLANK;
          blank_cnt   <= BW'(BLANK_SAMPLES - 1);
          dwell       <= '0;
        end else if (have_req) begin
          dwell <= DW'(auto_en);
        end else begin
          case (state)
            ST_IDLE: if (auto_en) begin
              cur_mode    <= MODE_ASK;
              mode_active <= 1'b1;
              state       <= ST_BLANK;
              blank_cnt   <= BW'(BLANK_SAMPLES - 1);
              dwell       <= '0;
            end
            ST_BLANK: if (blank_cnt == '0) begin
              state <= ST_RUN;
              dwell <= DW'(auto_en);
            end else begin
              blank_cnt <= blank_cnt - 1'b1;
            end
            ST_RUN: if (dwell_done) begin
              cur_mode  <= mode_t'(cur_mode + 2'd1);
              state     <= ST_BLANK;
              blank_cnt <= BW'(BLANK_SAMPLES - 1);
              dwell     <= '0;
            end else if (auto_en) begin
              dwell <= dwell + 1'b1;
            end
            default: state <= ST_IDLE;
          endcase
        end
      end else if (key_hit) begin
        req_valid <= 1'b1;
        req_mode  <= key_sel;
      end
    end
  end

  // A tick owns the cycle it lands in, which keeps loads at least one cycle apart.
  assign dac_load = pending && dac_ready && !tick;
  assign dac_data = dac_load ? pend_word : held_word;
  assign mode     = cur_mode;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pending     <= 1'b0;
      pend_word   <= MIDSCALE;
      held_word   <= MIDSCALE;
      overrun_cnt <= '0;
    end else if (tick) begin
      pending   <= 1'b1;
      pend_word <= tick_word;
      if (pending && overrun_cnt != 8'hFF) overrun_cnt <= overrun_cnt + 1'b1;
    end else if (dac_load) begin
      pending   <= 1'b0;
      held_word <= pend_word;
    end
  end

endmodule

// File: doc/mod_sample_sched.md
Name: mod_sample_sched

Overview:
Sample scheduler between the four modulator outputs (ASK/FSK/PSK/DPSK) and the serial DAC driver.
- Selects one modulated stream by key press or by automatic scan.
- Paces samples to the DAC at a fixed rate with a ready/load handshake.
- Inserts midscale blanking on every mode change so the DAC never outputs a mixed-mode glitch.
- Sits between the modulator blocks and the DAC driver, replacing direct mux selection.

Parameters:
- SAMPLE_DIV, 1000, clk cycles per sample tick (≥2).
- DWELL_TICKS, 5000, sample ticks per mode in auto-scan (≥1).
- BLANK_SAMPLES, 4, midscale samples emitted after each mode change (≥1).
- MIDSCALE, 10'd512, DAC code used for idle and blanking.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- set_ask  in  1  debounced single-cycle key pulse
- set_fsk  in  1  debounced single-cycle key pulse
- set_psk  in  1  debounced single-cycle key pulse
- set_dpsk  in  1  debounced single-cycle key pulse
- auto_en  in  1  level; 1 enables automatic mode scan
- ask_in  in  10  ASK sample
- fsk_in  in  10  FSK sample
- psk_in  in  10  PSK sample
- dpsk_in  in  10  DPSK sample
- dac_ready  in  1  DAC driver can accept a new word
- dac_load  out  1  single-cycle strobe; dac_data valid
- dac_data  out  10  word to DAC, held between loads
- mode  out  2  current mode: 0 ASK, 1 FSK, 2 PSK, 3 DPSK
- mode_active  out  1  a mode has been selected since reset
- overrun_cnt  out  8  saturating count of ticks lost to dac_ready low

Behaviour:
- Reset (asynchronous, reset_n=0): dac_data=MIDSCALE, dac_load=0, mode=0, mode_active=0, overrun_cnt=0, state=IDLE, all counters 0, pending=0.
- Tick generator: div counter 0..SAMPLE_DIV-1, free-running from reset. tick=1 for one cycle when count==SAMPLE_DIV-1.
- FSM states:
  - IDLE: word=MIDSCALE.
    - Key pulse → BLANK with the new mode.
    - auto_en=1 at a tick → BLANK with mode 0.
  - BLANK: word=MIDSCALE. After BLANK_SAMPLES ticks → RUN.
  - RUN: word = sample of the current mode, sampled on the tick cycle.
- Mode requests:
  - A key pulse latches req_mode and req_valid.
  - Simultaneous keys: priority ASK>FSK>PSK>DPSK.
  - A later key before the boundary overwrites the earlier request.
  - A request is applied only at the next tick, never mid-sample. On apply: mode updates, mode_active=1, blank counter reloads, state→BLANK.
  - A request equal to the current mode while in RUN is discarded: no blanking, dwell restarts.
- Auto-scan:
  - Active only when auto_en=1 and state≠IDLE.
  - Dwell counter counts ticks in RUN. At DWELL_TICKS, mode advances 0→1→2→3→0 and enters BLANK.
  - A key request at the same tick wins over auto-advance.
  - Any applied key request restarts dwell.
  - auto_en=0 freezes and clears dwell; the mode is retained.
- DAC handshake:
  - On a tick, the word is computed and pending=1.
  - dac_load=1 in the first cycle with pending=1 and dac_ready=1: dac_data registers the word in that same cycle, pending clears.
  - Best-case latency is tick+1 cycle.
  - If a tick arrives while pending=1: overrun_cnt increments (saturating at 255) and the pending word is replaced by the newer word.
  - dac_load is never asserted on consecutive cycles (SAMPLE_DIV≥2).
- Boundaries:
  - dac_ready stuck low: no loads; overrun counts once per tick.
  - Reset mid-handshake: pending dropped, outputs return to reset values immediately.
  - A key pulse in the same cycle as the tick is applied at that tick.

Decomposition:
- Shared package: mode encodings (MODE_ASK..MODE_DPSK), FSM state encodings, MIDSCALE constant.
- One natural sub-module: mss_tick_div (parameterised divider producing tick). The FSM, request latch, dwell counter and handshake stay in the top module.

Test Plan:
Bench settings: SAMPLE_DIV=4, DWELL_TICKS=3, BLANK_SAMPLES=2, dac_ready=1, inputs ask=100, fsk=200, psk=300, dpsk=400.
- Reset released, no keys, auto_en=0 → every 4 cycles one dac_load with dac_data=512; mode_active=0.
- set_psk pulse → at the next tick mode=2; 2 loads of 512, then loads of 300.
- set_ask and set_dpsk in the same cycle → mode=0; after blanking, data=100.
- auto_en=1 from IDLE → mode sequence 0,1,2,3,0. Each mode gives 2×512 then 3 sample loads; mode changes occur only on tick cycles.
- In RUN with dac_ready low for 10 ticks → no dac_load, overrun_cnt=9. On ready rising, one load carrying the latest word.
- reset_n low for 1 cycle while pending=1 → dac_load=0, dac_data=512, mode=0, overrun_cnt=0 asynchronously.
